// File: rtl/snn_ctrl_pkg.sv
// Shared control types and defaults for the spike-to-motor decoder.
// Holds the FSM state type, PWM defaults and the saturating clamp helper.
package snn_ctrl_pkg;

  localparam int PWM_W_DEF      = 8;
  localparam int BASE_DUTY_DEF  = 128;
  localparam int GAIN_SHIFT_DEF = 2;

  typedef enum logic {IDLE, ACCUM} state_e;

  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/spike_motor_decoder_pwm_gen.sv
// Free-running PWM with duty reload only on counter wrap, so every period is whole.
module pwm_gen #(
  parameter int PWM_W    = 8,
  parameter int RST_DUTY = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty_i,
  output logic             pwm_o
);

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] act_q, act_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    cnt_d = cnt_q + PWM_W'(1);
    act_d = (&cnt_q) ? duty_i : act_q;
    pwm_d = (cnt_q < act_q);
  end

  // Output is registered so it reads 0 while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      act_q <= PWM_W'(RST_DUTY);
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/spike_motor_decoder.sv
// Spike-rate window counter feeding a differential-drive mixer and two PWMs.
// Optional macro SNN_RATE_SMOOTH_EN publishes (prev + snapshot) >> 1 instead of raw rates.
module spike_motor_decoder
  import snn_ctrl_pkg::*;
#(
  parameter  int EXCNUM     = 2,
  parameter  int WIN_CYCLES = 1000,
  parameter  int PWM_W      = PWM_W_DEF,
  parameter  int BASE_DUTY  = BASE_DUTY_DEF,
  parameter  int GAIN_SHIFT = GAIN_SHIFT_DEF,
  localparam int CNT_W      = $clog2(WIN_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [EXCNUM-1:0] spike_in,
  output logic              pwm_left,
  output logic              pwm_right,
  output logic [CNT_W-1:0]  rate_left,
  output logic [CNT_W-1:0]  rate_right,
  output logic              rate_valid
);

  localparam int MIX_W = PWM_W + CNT_W + 1;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              win_q, win_d;
  logic [EXCNUM-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [EXCNUM-1:0][CNT_W-1:0]  snap, pub;
  logic [EXCNUM-1:0][CNT_W-1:0]  rate_q;
  logic [PWM_W-1:0]              duty_l_q, duty_r_q, duty_l_d, duty_r_d;
  logic                          valid_q;
  logic                          term;
  logic [CNT_W-1:0]              sh_l, sh_r;
  logic signed [MIX_W-1:0]       mix_l, mix_r;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = ACCUM;
      ACCUM:   state_d = ACCUM;
      default: state_d = IDLE;
    endcase
  end

  // The terminal-cycle spike is folded into the snapshot so nothing leaks across windows.
  always_comb begin
    logic [CNT_W:0] sum;
    logic [CNT_W:0] avg;
    term  = en && (win_q == CNT_W'(WIN_CYCLES - 1));
    win_d = win_q;
    cnt_d = cnt_q;
    for (int i = 0; i < EXCNUM; i++) begin
      sum     = {1'b0, cnt_q[i]} + (CNT_W + 1)'(spike_in[i]);
      snap[i] = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      avg     = {1'b0, rate_q[i]} + {1'b0, snap[i]};
`ifdef SNN_RATE_SMOOTH_EN
      pub[i]  = avg[CNT_W:1];
`else
      pub[i]  = snap[i] | (avg[0] & 1'b0 ? '0 : '0);
`endif
    end
    if (en) begin
      if (term) begin
        win_d = '0;
        cnt_d = '0;
      end else begin
        win_d = win_q + CNT_W'(1);
        cnt_d = snap;
      end
    end
  end

  always_comb begin
    sh_l     = pub[0] >> GAIN_SHIFT;
    sh_r     = pub[1] >> GAIN_SHIFT;
    mix_l    = MIX_W'(BASE_DUTY) - MIX_W'(sh_l) + MIX_W'(sh_r);
    mix_r    = MIX_W'(BASE_DUTY) - MIX_W'(sh_r) + MIX_W'(sh_l);
    duty_l_d = PWM_W'(clamp_int(int'(mix_l), 0, (1 << PWM_W) - 1));
    duty_r_d = PWM_W'(clamp_int(int'(mix_r), 0, (1 << PWM_W) - 1));
  end

  // Publish is driven by the terminal cycle itself, so it completes even if en drops after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      win_q    <= '0;
      cnt_q    <= '0;
      rate_q   <= '0;
      duty_l_q <= PWM_W'(BASE_DUTY);
      duty_r_q <= PWM_W'(BASE_DUTY);
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      valid_q <= term;
      if (term) begin
        rate_q   <= pub;
        duty_l_q <= duty_l_d;
        duty_r_q <= duty_r_d;
      end
    end
  end

  pwm_gen #(.PWM_W(PWM_W), .RST_DUTY(BASE_DUTY)) u_pwm_l (
    .clk(clk), .rst(rst), .duty_i(duty_l_q), .pwm_o(pwm_left)
  );

  pwm_gen #(.PWM_W(PWM_W), .RST_DUTY(BASE_DUTY)) u_pwm_r (
    .clk(clk), .rst(rst), .duty_i(duty_r_q), .pwm_o(pwm_right)
  );

  assign rate_left  = rate_q[0];
  assign rate_right = rate_q[1];
  assign rate_valid = valid_q;

endmodule

// File: tb/tb_spike_motor_decoder.sv
// Scoreboard bench: windows push hand-computed rates, a negedge monitor pops on rate_valid.
module tb_spike_motor_decoder;

  localparam int WIN = 16;
  localparam int CW  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic [1:0]    spike_in = 2'b00;
  logic          pwm_left, pwm_right, rate_valid;
  logic [CW-1:0] rate_left, rate_right;

  spike_motor_decoder #(
    .EXCNUM(2), .WIN_CYCLES(WIN), .PWM_W(8), .BASE_DUTY(128), .GAIN_SHIFT(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .pwm_left(pwm_left), .pwm_right(pwm_right),
    .rate_left(rate_left), .rate_right(rate_right), .rate_valid(rate_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int rl; int rr; int at; } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int hi_l, hi_r;
  bit meas = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick(input bit e, input logic [1:0] s);
    en = e;
    spike_in = s;
    @(negedge clk);
    if (meas) begin
      hi_l += int'(pwm_left);
      hi_r += int'(pwm_right);
    end
    @(posedge clk);
    #1;
  endtask

  // One full enabled window; s0/s1 bit i is the spike on window cycle i.
  task automatic window(input logic [15:0] s0, input logic [15:0] s1, input int rl, input int rr);
    for (int i = 0; i < WIN; i++) begin
      if (i == WIN - 1) q.push_back('{rl, rr, cyc + 1});
      tick(1'b1, {s1[i], s0[i]});
    end
  endtask

  task automatic measure_windows(input logic [15:0] s0, input logic [15:0] s1, input int rl, input int rr,
                                 input int dl, input int dr, input string nm);
    for (int w = 0; w < 20; w++) window(s0, s1, rl, rr);
    hi_l = 0; hi_r = 0; meas = 1'b1;
    for (int w = 0; w < 16; w++) window(s0, s1, rl, rr);
    meas = 1'b0;
    chk({nm, "_pwm_left_highs"}, hi_l, dl);
    chk({nm, "_pwm_right_highs"}, hi_r, dr);
  endtask

  always @(negedge clk) begin
    if (rst && rate_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_rate_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rate_left", int'(rate_left), e.rl);
        chk("rate_right", int'(rate_right), e.rr);
        chk("rate_valid_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rate_left", int'(rate_left), 0);
    chk("rst_rate_right", int'(rate_right), 0);
    chk("rst_rate_valid", int'(rate_valid), 0);
    chk("rst_pwm_left", int'(pwm_left), 0);
    chk("rst_pwm_right", int'(pwm_right), 0);
    rst = 1'b1;

    // Quiet network: rates 0, both motors at base duty.
    measure_windows(16'h0000, 16'h0000, 0, 0, 128, 128, "idle");
    // Left channel saturated with spikes: 128 - 4 / 128 + 4.
    measure_windows(16'hFFFF, 16'h0000, 16, 0, 124, 132, "left");
    // Mixed rates.
    window(16'h5555, 16'hFFFF, 8, 16);
    // Spike only on the terminal cycle belongs to the closing window.
    window(16'h0000, 16'h8000, 0, 1);
    window(16'h0000, 16'h0000, 0, 0);

    // en low for 5 cycles mid-window: spikes then ignored, publish shifted by 5.
    for (int i = 0; i < 8; i++) tick(1'b1, 2'b01);
    repeat (5) tick(1'b0, 2'b11);
    for (int i = 8; i < WIN; i++) begin
      if (i == WIN - 1) q.push_back('{8, 0, cyc + 1});
      tick(1'b1, 2'b00);
    end

    // PWM keeps running with en low at the newly published duties 126/130.
    repeat (300) tick(1'b0, 2'b00);
    hi_l = 0; hi_r = 0; meas = 1'b1;
    repeat (256) tick(1'b0, 2'b11);
    meas = 1'b0;
    chk("en_low_pwm_left_highs", hi_l, 126);
    chk("en_low_pwm_right_highs", hi_r, 130);

    // Asynchronous reset mid-window with counts pending.
    repeat (9) tick(1'b1, 2'b11);
    rst = 1'b0;
    #2;
    chk("midrst_rate_left", int'(rate_left), 0);
    chk("midrst_rate_right", int'(rate_right), 0);
    chk("midrst_rate_valid", int'(rate_valid), 0);
    chk("midrst_pwm_left", int'(pwm_left), 0);
    chk("midrst_pwm_right", int'(pwm_right), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    window(16'h0000, 16'h0421, 0, 3);
    repeat (4) tick(1'b0, 2'b00);
    chk("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
